// File: rtl/gate_ctrl.sv
// Measurement sequencer for the BCD counter: clear, timed counting gate, settle,
// store, then auto/manual range update. Every output comes straight from a flop.
module gate_ctrl #(
    parameter logic [15:0] GATE0   = 16'd1000,
    parameter logic [15:0] GATE1   = 16'd100,
    parameter logic [15:0] GATE2   = 16'd10,
    parameter logic [1:0]  RST_RNG = 2'd0
) (
    input  logic       CP,
    input  logic       nRST,
    input  logic       run,
    input  logic       auto_rng,
    input  logic [1:0] man_rng,
    input  logic       ovf,
    input  logic       under,
    output logic       C_Clear,
    output logic       C_Enable,
    output logic       C_Store,
    output logic [1:0] T_sel,
    output logic [1:0] Status_Value,
    output logic       done,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_STORE, S_RANGE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  rng_q, rng_d;
    logic [1:0]  stat_q, stat_d;
    logic        ovf_q, ovf_d;
    logic        under_q, under_d;
    logic        clr_q, en_q, st_q, done_q, busy_q;
    logic [15:0] gate_len;

    always_comb begin
        case (rng_q)
            2'd0:    gate_len = GATE0;
            2'd1:    gate_len = GATE1;
            default: gate_len = GATE2;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rng_d   = rng_q;
        stat_d  = stat_q;
        ovf_d   = ovf_q;
        under_d = under_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_CLEAR;
            S_CLEAR: begin
                cnt_d   = gate_len;
                state_d = S_GATE;
            end
            S_GATE: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q <= 16'd1) state_d = S_SETTLE;
            end
            S_SETTLE: state_d = S_STORE;
            S_STORE: begin
                ovf_d   = ovf;
                under_d = under;
                state_d = S_RANGE;
            end
            S_RANGE: begin
                if (auto_rng) begin
                    // overflow wins when both flags are set
                    if (ovf_q) begin
                        if (rng_q < 2'd2) begin
                            rng_d  = rng_q + 2'd1;
                            stat_d = 2'b11;
                        end else begin
                            stat_d = 2'b01;
                        end
                    end else if (under_q) begin
                        if (rng_q > 2'd0) begin
                            rng_d  = rng_q - 2'd1;
                            stat_d = 2'b11;
                        end else begin
                            stat_d = 2'b10;
                        end
                    end else begin
                        stat_d = 2'b00;
                    end
                end else begin
                    rng_d  = (man_rng == 2'd3) ? 2'd2 : man_rng;
                    stat_d = ovf_q ? 2'b01 : 2'b00;
                end
                state_d = run ? S_CLEAR : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state itself.
    always_ff @(posedge CP or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            rng_q   <= RST_RNG;
            stat_q  <= 2'b00;
            ovf_q   <= 1'b0;
            under_q <= 1'b0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            st_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rng_q   <= rng_d;
            stat_q  <= stat_d;
            ovf_q   <= ovf_d;
            under_q <= under_d;
            clr_q   <= (state_d == S_CLEAR);
            en_q    <= (state_d == S_GATE);
            st_q    <= (state_d == S_STORE);
            done_q  <= (state_d == S_RANGE);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign C_Clear      = clr_q;
    assign C_Enable     = en_q;
    assign C_Store      = st_q;
    assign T_sel        = rng_q;
    assign Status_Value = stat_q;
    assign done         = done_q;
    assign busy         = busy_q;

endmodule
